instr_prefetch: RTL

Instruction fetch front end for the single-cycle RISC-V core. It sits between a multi-cycle instruction memory (request/grant/response handshake) and the decode/execute datapath. It runs ahead of execution, buffering up to DEPTH fetched words with their PCs in a small FIFO. It flushes and restarts cleanly when the core redirects on a taken branch, JAL or JALR.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_prefetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared types and constants for the instruction prefetch front end.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), presented when nothing is buffered
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // One buffered fetch: the word and the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo                                                           |
// | Synchronous FIFO of fetch entries with flush, count and a head view  |
// | that reads as {pc=0, instr=NOP} while empty.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [AW:0]  count,
  output logic         head_valid,
  output fetch_entry_t head
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot the same edge, so push is accepted when full if paired with a pop
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != FULL_CNT) || do_pop);
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr]
                                 : fetch_entry_t'{pc: 32'h0, instr: NOP_INSTR};

  // Pointer and occupancy bookkeeping; flush empties the queue outright
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch                                                       |
// | Fetch front end: issues one outstanding imem request at a time,      |
// | buffers fetched words with PCs, flushes and restarts on redirect.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_prefetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] BOOT_PC  = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  redirect_base;
  logic         req_q;
  logic         granted;
  logic         push;
  logic         pop;
  logic [AW:0]  count;
  logic [AW:0]  count_next;
  logic         head_valid;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
  assign granted       = (state == REQ) && req_q && imem_gnt;
  // A response landing together with a redirect belongs to the old stream
  assign push          = (state == WAIT) && imem_rvalid && !redirect;
  assign pop           = head_valid && instr_ready && !redirect;
  // fetch_pc was already advanced at grant time, so the word belongs to fetch_pc-4
  assign push_entry    = fetch_entry_t'{pc: fetch_pc - 32'd4, instr: imem_rdata};

  assign imem_req      = req_q;
  assign imem_addr     = fetch_pc;
  assign instr_valid   = head_valid;
  assign instr         = head.instr;
  assign instr_pc      = head.pc;

  // Occupancy after this edge; feeds the registered request decision
  always_comb begin
    count_next = count;
    if (redirect)          count_next = '0;
    else if (push && !pop) count_next = count + (AW + 1)'(1);
    else if (pop && !push) count_next = count - (AW + 1)'(1);
  end

  // Sequencer transitions; a granted-but-unanswered request always ends in DROP on redirect
  always_comb begin
    state_next = state;
    case (state)
      REQ: begin
        if (granted) state_next = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect)         state_next = imem_rvalid ? REQ : DROP;
        else if (imem_rvalid) state_next = REQ;
      end
      DROP: begin
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
  end

  // State, fetch address and registered request; nothing outstanding while in REQ
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= REQ;
      fetch_pc <= BOOT_PC;
      req_q    <= 1'b0;
    end else begin
      state <= state_next;
      req_q <= (state_next == REQ) && (count_next < FULL_CNT);
      if (redirect)     fetch_pc <= redirect_base;
      else if (granted) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

endmodule
`default_nettype wire
